// File: rtl/inst_mem_loader.sv
// Byte-loaded instruction memory: streams a program image in, then serves big-endian word reads.
// Optional misaligned-read trap enabled by defining INST_MEM_MISALIGN_TRAP_EN.
module inst_mem_loader #(
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_start,
    input  logic                    load_valid,
    input  logic [7:0]              load_data,
    input  logic                    load_last,
    output logic                    load_ready,
    output logic                    load_done,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [8*WORD_BYTES-1:0] rd_data,
    output logic                    rd_valid,
    output logic                    rd_err
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic                    load_done_q, load_done_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [8*WORD_BYTES-1:0] rd_data_q, rd_data_d;
    logic [8*WORD_BYTES-1:0] rd_word;
    logic [PTR_W-1:0]        base;
    logic                    beat;
    logic                    final_beat;
    logic                    rd_fire;
    logic                    unused_addr;
    logic [7:0]              mem [DEPTH];

`ifdef INST_MEM_MISALIGN_TRAP_EN
    localparam logic [PTR_W-1:0] OFF_MASK = PTR_W'(WORD_BYTES - 1);
    logic rd_err_q, rd_err_d;
    logic misalign;
    assign misalign = (base & OFF_MASK) != '0;
`endif

    assign base        = rd_addr[PTR_W-1:0];
    assign unused_addr = ^rd_addr;
    assign beat        = (state_q == LOAD) && load_valid;
    assign final_beat  = beat && (load_last || (ptr_q == PTR_W'(DEPTH - 1)));
    assign rd_fire     = (state_q == RUN) && rd_en && !load_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            load_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
`ifdef INST_MEM_MISALIGN_TRAP_EN
            rd_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            load_done_q <= load_done_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
`ifdef INST_MEM_MISALIGN_TRAP_EN
            rd_err_q    <= rd_err_d;
`endif
        end
    end

    // Storage has no reset so a reset mid-load keeps the bytes already written.
    always_ff @(posedge clk) begin
        if (beat && !rst) begin
            mem[ptr_q] <= load_data;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_start) state_d = LOAD;
            LOAD:    if (final_beat) state_d = RUN;
            RUN:     if (load_start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Word gather: lowest address lands in the MSB byte, indices wrap within the memory.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            rd_word[8*(WORD_BYTES-1-i) +: 8] = mem[base + PTR_W'(i)];
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        load_done_d = 1'b0;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
`ifdef INST_MEM_MISALIGN_TRAP_EN
        rd_err_d    = 1'b0;
`endif
        if (load_start && (state_q != LOAD)) begin
            ptr_d = '0;
        end else if (beat) begin
            ptr_d       = ptr_q + 1'b1;
            load_done_d = final_beat;
        end
        if (rd_fire) begin
            rd_valid_d = 1'b1;
`ifdef INST_MEM_MISALIGN_TRAP_EN
            rd_err_d  = misalign;
            rd_data_d = misalign ? '0 : rd_word;
`else
            rd_data_d = rd_word;
`endif
        end
    end

    always_comb begin
        load_ready = (state_q == LOAD);
        load_done  = load_done_q;
        rd_valid   = rd_valid_q;
        rd_data    = rd_data_q;
`ifdef INST_MEM_MISALIGN_TRAP_EN
        rd_err     = rd_err_q;
`else
        rd_err     = 1'b0;
`endif
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader (DEPTH=256, WORD_BYTES=4); honours INST_MEM_MISALIGN_TRAP_EN.
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;
    logic        load_ready;
    logic        load_done;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_err;

    int          checks = 0;
    int          fails  = 0;
    int          done_pulses = 0;
    int          loads_completed = 0;
    logic [32:0] exp_q [$];
    logic [7:0]  model [256];
    logic [7:0]  model_ptr;
    logic [31:0] last_data = '0;

`ifdef INST_MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    inst_mem_loader #(.DEPTH(256), .ADDR_W(32), .WORD_BYTES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_done  (load_done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_err     (rd_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rd_valid must match the oldest outstanding expected read.
    always @(negedge clk) begin
        if (rst === 1'b0 && load_done === 1'b1) done_pulses++;
        if (rst === 1'b0 && rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_rd_valid", 64'(rd_valid), 64'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                checkOutput("rd_data", 64'(rd_data), 64'(e[31:0]));
                checkOutput("rd_err", 64'(rd_err), 64'(e[32]));
            end
        end
    end

    function automatic logic [32:0] modelWord(input logic [31:0] addr);
        logic [7:0] a;
        a = addr[7:0];
        if (TRAP && addr[1:0] != 2'b00) return {1'b1, 32'h0};
        return {1'b0, model[a], model[8'(a + 8'd1)], model[8'(a + 8'd2)], model[8'(a + 8'd3)]};
    endfunction

    task automatic applyStimulus(input logic [31:0] addr, input logic [32:0] expected);
        rd_en   = 1'b1;
        rd_addr = addr;
        exp_q.push_back(expected);
        if (!expected[32]) last_data = expected[31:0];
        else last_data = 32'h0;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic driveBeat(input logic [7:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        if (load_ready) begin
            model[model_ptr] = data;
            model_ptr++;
        end
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic startLoad();
        load_start = 1'b1;
        model_ptr  = 8'd0;
        tick();
        load_start = 1'b0;
    endtask

    task automatic loadImage(input int n, input bit use_last, input int gap_at, input logic [7:0] xorv);
        startLoad();
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                repeat (3) tick();
            end
            driveBeat(8'(i) ^ xorv, use_last && (i == n - 1));
        end
        checkOutput("load_done_pulse", 64'(load_done), 64'd1);
        loads_completed++;
        tick();
        checkOutput("load_done_clear", 64'(load_done), 64'd0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
        load_last = 1'b0; rd_en = 1'b0; rd_addr = '0; model_ptr = '0;
        for (int i = 0; i < 256; i++) model[i] = 8'hxx;
        doReset();
        checkOutput("reset_load_ready", 64'(load_ready), 64'd0);
        checkOutput("reset_load_done", 64'(load_done), 64'd0);
        checkOutput("reset_rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("reset_rd_data", 64'(rd_data), 64'd0);
        checkOutput("reset_rd_err", 64'(rd_err), 64'd0);

        // Scenario 1: 12-byte image terminated by load_last.
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        loadImage(12, 1'b1, -1, 8'h00);
        checkOutput("run_load_ready", 64'(load_ready), 64'd0);
        applyStimulus(32'd0, {1'b0, 32'h00010203});
        applyStimulus(32'd4, {1'b0, 32'h04050607});
        applyStimulus(32'd8, {1'b0, 32'h08090A0B});
        tick();
        checkOutput("rd_valid_idle", 64'(rd_valid), 64'd0);
        checkOutput("rd_data_hold", 64'(rd_data), 64'(last_data));

        // Scenario 2: stall after byte 05 for three cycles.
        loadImage(12, 1'b1, 6, 8'h00);
        applyStimulus(32'd0, {1'b0, 32'h00010203});
        applyStimulus(32'd4, {1'b0, 32'h04050607});
        applyStimulus(32'd8, {1'b0, 32'h08090A0B});

        // Scenario 3: fill all 256 bytes, no load_last; extra byte must be refused.
        loadImage(256, 1'b0, -1, 8'h00);
        checkOutput("full_load_ready", 64'(load_ready), 64'd0);
        driveBeat(8'h77, 1'b0);
        applyStimulus(32'd254, TRAP ? {1'b1, 32'h0} : {1'b0, 32'hFEFF0001});
        applyStimulus(32'd0, {1'b0, 32'h00010203});
        applyStimulus(32'h0000_01FC, modelWord(32'h0000_01FC));

        // Scenario 4: load_start beats a simultaneous rd_en.
        rd_en = 1'b1; rd_addr = 32'd16; load_start = 1'b1; model_ptr = 8'd0;
        tick();
        rd_en = 1'b0; load_start = 1'b0;
        checkOutput("collision_load_ready", 64'(load_ready), 64'd1);
        checkOutput("collision_rd_valid", 64'(rd_valid), 64'd0);
        rd_en = 1'b1; rd_addr = 32'd0;
        tick();
        rd_en = 1'b0;
        checkOutput("load_rd_ignored", 64'(rd_valid), 64'd0);
        checkOutput("load_rd_data_hold", 64'(rd_data), 64'(last_data));
        for (int i = 0; i < 4; i++) driveBeat(8'h40 + 8'(i), i == 3);
        loads_completed++;
        tick();
        applyStimulus(32'd0, {1'b0, 32'h40414243});
        applyStimulus(32'd4, modelWord(32'd4));

        // Scenario 5: reset after six beats of a new load.
        startLoad();
        for (int i = 0; i < 6; i++) driveBeat(8'hC0 + 8'(i), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midreset_load_ready", 64'(load_ready), 64'd0);
        checkOutput("midreset_rd_valid", 64'(rd_valid), 64'd0);
        rd_en = 1'b1; rd_addr = 32'd0;
        tick();
        tick();
        rd_en = 1'b0;
        checkOutput("idle_rd_ignored", 64'(rd_valid), 64'd0);
        loadImage(12, 1'b1, -1, 8'hA5);
        applyStimulus(32'd0, {1'b0, 32'hA5A4A7A6});
        applyStimulus(32'd12, modelWord(32'd12));

        // Scenario 6: misaligned then aligned read after reloading 00..0B.
        loadImage(12, 1'b1, -1, 8'h00);
        applyStimulus(32'd2, TRAP ? {1'b1, 32'h0} : {1'b0, 32'h02030405});
        applyStimulus(32'd4, {1'b0, 32'h04050607});
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 1023));
            applyStimulus(a, modelWord(a));
        end

        repeat (3) tick();
        checkOutput("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        checkOutput("load_done_count", 64'(done_pulses), 64'(loads_completed));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
